// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the decryption-order key scheduler.
// Used by aes_keyexp_word and aes_inv_keysched.
package aes_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BLOCK_W   = 128;
    localparam int unsigned KEY_W     = 256;
    localparam int unsigned ROWS      = 15;
    localparam int unsigned LANES     = 4;
    localparam int unsigned WIN_DEPTH = 8;

    typedef enum logic [1:0] {
        MODE_AES128 = 2'b00,
        MODE_AES192 = 2'b01,
        MODE_AES256 = 2'b10,
        MODE_RSVD   = 2'b11
    } aes_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_EMIT   = 2'd2
    } ks_state_e;

    function automatic logic [3:0] nk_of(aes_mode_e m);
        case (m)
            MODE_AES128: return 4'd4;
            MODE_AES192: return 4'd6;
            default:     return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(aes_mode_e m);
        case (m)
            MODE_AES128: return 4'd10;
            MODE_AES192: return 4'd12;
            default:     return 4'd14;
        endcase
    endfunction

    // Byte x of the forward S-box lives at bits [(255-x)*8 +: 8].
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(logic [7:0] x);
        return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column; byte 0 is the most significant byte.
    function automatic logic [31:0] inv_mix_col(logic [31:0] c);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int k = 0; k < 4; k++) begin
            a[k]  = c[31 - 8*k -: 8];
            x2[k] = xtime(a[k]);
            x4[k] = xtime(x2[k]);
            x8[k] = xtime(x4[k]);
            m9[k] = x8[k] ^ a[k];
            mb[k] = x8[k] ^ x2[k] ^ a[k];
            md[k] = x8[k] ^ x4[k] ^ a[k];
            me[k] = x8[k] ^ x4[k] ^ x2[k];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

endpackage

// File: rtl/aes_keyexp_word.sv
// Combinational AES key-expansion step: produces w[i] from w[i-1], w[i-Nk],
// i mod Nk, Nk and the current rcon.
module aes_keyexp_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] w_prev_i,
    input  logic [WORD_W-1:0] w_old_i,
    input  logic [2:0]        imod_i,
    input  logic [3:0]        nk_i,
    input  logic [7:0]        rcon_i,
    output logic [WORD_W-1:0] w_next_o
);

    logic              is_rot;
    logic              is_sub;
    logic [WORD_W-1:0] sub_in;
    logic [WORD_W-1:0] sub_out;
    logic [WORD_W-1:0] t;

    // One S-box lookup per byte, shared between the RotWord and plain SubWord cases.
    always_comb begin
        is_rot  = (imod_i == 3'd0);
        is_sub  = (nk_i == 4'd8) && (imod_i == 3'd4);
        sub_in  = is_rot ? {w_prev_i[23:0], w_prev_i[31:24]} : w_prev_i;
        sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                   sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
        t = w_prev_i;
        if (is_rot) begin
            t = sub_out ^ {rcon_i, 24'h000000};
        end else if (is_sub) begin
            t = sub_out;
        end
        w_next_o = w_old_i ^ t;
    end

endmodule

// File: rtl/aes_inv_keysched.sv
// AES-128/192/256 key expander that streams round keys from Nr down to 0.
// Define AES_INV_MIXCOL_EN to emit the equivalent-inverse-cipher schedule.
module aes_inv_keysched
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic [KEY_W-1:0]   key_in,
    input  logic               start,
    output logic               busy,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic [BLOCK_W-1:0] rk_data,
    output logic [3:0]         rk_round,
    output logic               rk_last
);

    ks_state_e          state_q, state_d;
    logic               busy_q, busy_d;
    logic               rk_valid_q, rk_valid_d;
    logic [BLOCK_W-1:0] rk_data_q, rk_data_d;
    logic [3:0]         rk_round_q, rk_round_d;
    logic               rk_last_q, rk_last_d;
    logic [3:0]         nk_q, nk_d;
    logic [3:0]         nr_q, nr_d;
    logic [5:0]         idx_q, idx_d;
    logic [2:0]         imod_q, imod_d;
    logic [7:0]         rcon_q, rcon_d;
    logic [WORD_W-1:0]  win_q [WIN_DEPTH];
    logic [WORD_W-1:0]  win_d [WIN_DEPTH];
    logic [WORD_W-1:0]  mem_q [ROWS][LANES];

    aes_mode_e          mode_c;
    logic               accept_c;
    logic [3:0]         nk_sel_c;
    logic [8:0]         key_sh_c;
    logic [KEY_W-1:0]   key_al_c;
    logic [WORD_W-1:0]  w_new_c;
    logic               expand_done_c;
    logic [3:0]         nxt_round_c;
    logic [BLOCK_W-1:0] nxt_raw_c;
    logic [BLOCK_W-1:0] nxt_key_c;

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_data  = rk_data_q;
    assign rk_round = rk_round_q;
    assign rk_last  = rk_last_q;

    // Left-justify the used key field so w[j] sits at [255-32j -: 32].
    always_comb begin
        mode_c   = aes_mode_e'(mode);
        accept_c = (state_q == ST_IDLE) && start && (mode_c != MODE_RSVD);
        nk_sel_c = nk_of(mode_c);
        key_sh_c = 9'(4'd8 - nk_sel_c) << 5;
        key_al_c = key_in << key_sh_c;
    end

    aes_keyexp_word u_word (
        .w_prev_i (win_q[0]),
        .w_old_i  (win_q[3'(nk_q - 4'd1)]),
        .imod_i   (imod_q),
        .nk_i     (nk_q),
        .rcon_i   (rcon_q),
        .w_next_o (w_new_c)
    );

    assign expand_done_c = (idx_q == {nr_q, 2'b11});

    // The last row is not in storage yet when EXPAND finishes, so take it from the window.
    always_comb begin
        nxt_round_c = (state_q == ST_EXPAND) ? nr_q : 4'(rk_round_q - 4'd1);
        if (state_q == ST_EXPAND) begin
            nxt_raw_c = {win_q[2], win_q[1], win_q[0], w_new_c};
        end else begin
            nxt_raw_c = {mem_q[nxt_round_c][0], mem_q[nxt_round_c][1],
                         mem_q[nxt_round_c][2], mem_q[nxt_round_c][3]};
        end
`ifdef AES_INV_MIXCOL_EN
        if ((nxt_round_c != 4'd0) && (nxt_round_c != nr_q)) begin
            nxt_key_c = {inv_mix_col(nxt_raw_c[127:96]), inv_mix_col(nxt_raw_c[95:64]),
                         inv_mix_col(nxt_raw_c[63:32]),  inv_mix_col(nxt_raw_c[31:0])};
        end else begin
            nxt_key_c = nxt_raw_c;
        end
`else
        nxt_key_c = nxt_raw_c;
`endif
    end

    always_ff @(posedge clk) begin
        if (accept_c) begin
            for (int j = 0; j < 8; j++) begin
                if (4'(j) < nk_sel_c) begin
                    mem_q[j / 4][j % 4] <= key_al_c[255 - 32*j -: 32];
                end
            end
        end else if (state_q == ST_EXPAND) begin
            mem_q[idx_q[5:2]][idx_q[1:0]] <= w_new_c;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        rk_valid_d = rk_valid_q;
        rk_data_d  = rk_data_q;
        rk_round_d = rk_round_q;
        rk_last_d  = rk_last_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        idx_d      = idx_q;
        imod_d     = imod_q;
        rcon_d     = rcon_q;
        for (int k = 0; k < int'(WIN_DEPTH); k++) begin
            win_d[k] = win_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_EXPAND;
                    busy_d  = 1'b1;
                    nk_d    = nk_sel_c;
                    nr_d    = nr_of(mode_c);
                    idx_d   = 6'(nk_sel_c);
                    imod_d  = 3'd0;
                    rcon_d  = 8'h01;
                    for (int k = 0; k < int'(WIN_DEPTH); k++) begin
                        win_d[k] = key_in[32*k +: 32];
                    end
                end
            end

            ST_EXPAND: begin
                win_d[0] = w_new_c;
                for (int k = 1; k < int'(WIN_DEPTH); k++) begin
                    win_d[k] = win_q[k-1];
                end
                idx_d  = idx_q + 6'd1;
                imod_d = (imod_q == 3'(nk_q - 4'd1)) ? 3'd0 : imod_q + 3'd1;
                if (imod_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (expand_done_c) begin
                    state_d    = ST_EMIT;
                    rk_valid_d = 1'b1;
                    rk_round_d = nxt_round_c;
                    rk_data_d  = nxt_key_c;
                    rk_last_d  = 1'b0;
                end
            end

            ST_EMIT: begin
                if (rk_ready) begin
                    if (rk_round_q != 4'd0) begin
                        rk_round_d = nxt_round_c;
                        rk_data_d  = nxt_key_c;
                        rk_last_d  = (nxt_round_c == 4'd0);
                    end else begin
                        state_d    = ST_IDLE;
                        busy_d     = 1'b0;
                        rk_valid_d = 1'b0;
                        rk_data_d  = '0;
                        rk_round_d = 4'd0;
                        rk_last_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_data_q  <= '0;
            rk_round_q <= 4'd0;
            rk_last_q  <= 1'b0;
            nk_q       <= 4'd0;
            nr_q       <= 4'd0;
            idx_q      <= 6'd0;
            imod_q     <= 3'd0;
            rcon_q     <= 8'h01;
            for (int k = 0; k < int'(WIN_DEPTH); k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            rk_valid_q <= rk_valid_d;
            rk_data_q  <= rk_data_d;
            rk_round_q <= rk_round_d;
            rk_last_q  <= rk_last_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            idx_q      <= idx_d;
            imod_q     <= imod_d;
            rcon_q     <= rcon_d;
            for (int k = 0; k < int'(WIN_DEPTH); k++) begin
                win_q[k] <= win_d[k];
            end
        end
    end

endmodule

// File: tb/tb_aes_inv_keysched.sv
// Directed bench for aes_inv_keysched using FIPS-197 key schedules.
module tb_aes_inv_keysched;

    localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] RK0     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R192_12 = 128'ha4970a331a78dc09c418c271e3a41d5d;
    localparam logic [127:0] R192_1  = 128'h10111213141516175846f2f95c43f4fe;
    localparam logic [127:0] R256_14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [127:0] R256_1  = 128'h101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   mode;
    logic [255:0] key_in;
    logic         start;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] rk128 [11];
    logic [127:0] cap_data  [16];
    logic [3:0]   cap_round [16];
    logic         cap_last  [16];
    int           n_cap;
    int           n_cyc;

    aes_inv_keysched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .key_in   (key_in),
        .start    (start),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_round (rk_round),
        .rk_last  (rk_last)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix(logic [127:0] s);
        logic [127:0] r = '0;
        logic [7:0] b0, b1, b2, b3;
        for (int c = 0; c < 4; c++) begin
            b0 = s[127 - 32*c -: 8];
            b1 = s[119 - 32*c -: 8];
            b2 = s[111 - 32*c -: 8];
            b3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = gmul(b0, 8'h0e) ^ gmul(b1, 8'h0b) ^ gmul(b2, 8'h0d) ^ gmul(b3, 8'h09);
            r[119 - 32*c -: 8] = gmul(b0, 8'h09) ^ gmul(b1, 8'h0e) ^ gmul(b2, 8'h0b) ^ gmul(b3, 8'h0d);
            r[111 - 32*c -: 8] = gmul(b0, 8'h0d) ^ gmul(b1, 8'h09) ^ gmul(b2, 8'h0e) ^ gmul(b3, 8'h0b);
            r[103 - 32*c -: 8] = gmul(b0, 8'h0b) ^ gmul(b1, 8'h0d) ^ gmul(b2, 8'h09) ^ gmul(b3, 8'h0e);
        end
        return r;
    endfunction

    // Expected output key for round r out of nr, given the raw schedule word block.
    function automatic logic [127:0] xf(logic [127:0] raw, int r, int nr);
`ifdef AES_INV_MIXCOL_EN
        if (r != 0 && r != nr) return inv_mix(raw);
`endif
        return (nr >= 0) ? raw : raw;
    endfunction

    task automatic do_start(input logic [1:0] m, input logic [255:0] k);
        @(negedge clk);
        mode   = m;
        key_in = k;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_first_valid(output int cyc);
        cyc = 1;
        while (rk_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic collect_keys(input bit rand_ready, input int budget);
        bit done = 1'b0;
        bit stalled = 1'b0;
        logic [127:0] hd = '0;
        logic [3:0]   hr = '0;
        logic         hl = 1'b0;
        n_cap = 0;
        n_cyc = 0;
        while (!done && n_cyc < budget) begin
            if (stalled) begin
                n_cmp++;
                if (rk_valid !== 1'b1 || rk_data !== hd || rk_round !== hr || rk_last !== hl) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b d=%h r=%0d l=%b, need v=1 d=%h r=%0d l=%b",
                             rk_valid, rk_data, rk_round, rk_last, hd, hr, hl);
                end
            end
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (rk_valid === 1'b1) begin
                if (rk_ready) begin
                    if (n_cap < 16) begin
                        cap_data[n_cap]  = rk_data;
                        cap_round[n_cap] = rk_round;
                        cap_last[n_cap]  = rk_last;
                    end
                    n_cap++;
                    if (rk_last === 1'b1) done = 1'b1;
                end else begin
                    stalled = 1'b1;
                    hd = rk_data;
                    hr = rk_round;
                    hl = rk_last;
                end
            end
            @(negedge clk);
            n_cyc++;
        end
        rk_ready = 1'b0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL collect_timeout: got %0d keys in %0d cycles, need a last key", n_cap, n_cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b need 0", busy); end
        n_cmp++; if (rk_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b need 0", rk_valid); end
        n_cmp++; if (rk_data !== '0)    begin n_err++; $display("FAIL reset_data: got %h need 0", rk_data); end
        n_cmp++; if (rk_round !== 4'd0) begin n_err++; $display("FAIL reset_round: got %0d need 0", rk_round); end
        n_cmp++; if (rk_last !== 1'b0)  begin n_err++; $display("FAIL reset_last: got %b need 0", rk_last); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_aes128_stream(input string tag);
        n_cmp++;
        if (n_cap !== 11) begin n_err++; $display("FAIL %s_count: got %0d need 11", tag, n_cap); end
        for (int k = 0; k < n_cap && k < 11; k++) begin
            n_cmp++;
            if (cap_round[k] !== 4'(10 - k) || cap_data[k] !== xf(rk128[10 - k], 10 - k, 10)
                || cap_last[k] !== (k == 10)) begin
                n_err++;
                $display("FAIL %s_key%0d: got r=%0d d=%h l=%b need r=%0d d=%h l=%b", tag, k,
                         cap_round[k], cap_data[k], cap_last[k], 10 - k,
                         xf(rk128[10 - k], 10 - k, 10), (k == 10));
            end
        end
    endtask

    task automatic test_aes128();
        int cyc;
        do_start(2'b00, K128);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL a128_busy_c1: got %b need 1", busy); end
        wait_first_valid(cyc);
        n_cmp++; if (cyc != 41) begin n_err++; $display("FAIL a128_latency: got cycle %0d need 41", cyc); end
        n_cmp++;
        if (rk_round !== 4'd10 || rk_data !== rk128[10]) begin
            n_err++; $display("FAIL a128_first: got r=%0d d=%h need r=10 d=%h", rk_round, rk_data, rk128[10]);
        end
        collect_keys(1'b0, 64);
        n_cmp++; if (n_cyc != 11) begin n_err++; $display("FAIL a128_xfer_cycles: got %0d need 11", n_cyc); end
        check_aes128_stream("a128");
        n_cmp++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_data !== '0) begin
            n_err++; $display("FAIL a128_done: got busy=%b v=%b d=%h need 0 0 0", busy, rk_valid, rk_data);
        end
    endtask

    task automatic test_aes192();
        int cyc;
        do_start(2'b01, K192);
        wait_first_valid(cyc);
        n_cmp++; if (cyc != 47) begin n_err++; $display("FAIL a192_latency: got cycle %0d need 47", cyc); end
        n_cmp++;
        if (rk_round !== 4'd12 || rk_data !== R192_12) begin
            n_err++; $display("FAIL a192_first: got r=%0d d=%h need r=12 d=%h", rk_round, rk_data, R192_12);
        end
        collect_keys(1'b0, 64);
        n_cmp++; if (n_cap != 13) begin n_err++; $display("FAIL a192_count: got %0d need 13", n_cap); end
        if (n_cap == 13) begin
            n_cmp++;
            if (cap_round[11] !== 4'd1 || cap_data[11] !== xf(R192_1, 1, 12)) begin
                n_err++; $display("FAIL a192_round1: got r=%0d d=%h need r=1 d=%h", cap_round[11], cap_data[11], xf(R192_1, 1, 12));
            end
            n_cmp++;
            if (cap_round[12] !== 4'd0 || cap_data[12] !== RK0 || cap_last[12] !== 1'b1) begin
                n_err++; $display("FAIL a192_round0: got r=%0d d=%h l=%b need r=0 d=%h l=1", cap_round[12], cap_data[12], cap_last[12], RK0);
            end
        end
    endtask

    task automatic test_aes256();
        int cyc;
        do_start(2'b10, K256);
        wait_first_valid(cyc);
        n_cmp++; if (cyc != 53) begin n_err++; $display("FAIL a256_latency: got cycle %0d need 53", cyc); end
        n_cmp++;
        if (rk_round !== 4'd14 || rk_data !== R256_14) begin
            n_err++; $display("FAIL a256_first: got r=%0d d=%h need r=14 d=%h", rk_round, rk_data, R256_14);
        end
        collect_keys(1'b0, 64);
        n_cmp++; if (n_cap != 15) begin n_err++; $display("FAIL a256_count: got %0d need 15", n_cap); end
        if (n_cap == 15) begin
            n_cmp++;
            if (cap_round[13] !== 4'd1 || cap_data[13] !== xf(R256_1, 1, 14)) begin
                n_err++; $display("FAIL a256_round1: got r=%0d d=%h need r=1 d=%h", cap_round[13], cap_data[13], xf(R256_1, 1, 14));
            end
            n_cmp++;
            if (cap_round[14] !== 4'd0 || cap_data[14] !== RK0 || cap_last[14] !== 1'b1) begin
                n_err++; $display("FAIL a256_round0: got r=%0d d=%h l=%b need r=0 d=%h l=1", cap_round[14], cap_data[14], cap_last[14], RK0);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        do_start(2'b00, K128);
        wait_first_valid(cyc);
        rk_ready = 1'b0;
        mode     = 2'b01;
        key_in   = K256;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || rk_round !== 4'd10 || rk_data !== rk128[10]) begin
            n_err++; $display("FAIL bp_start_ignored: got busy=%b r=%0d d=%h need 1 10 %h", busy, rk_round, rk_data, rk128[10]);
        end
        collect_keys(1'b1, 400);
        check_aes128_stream("bp");
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_done_busy: got %b need 0", busy); end
    endtask

    task automatic test_mode_rsvd();
        @(negedge clk);
        mode   = 2'b11;
        key_in = K128;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rsvd_busy: got %b need 0", busy); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            n_err++; $display("FAIL rsvd_idle: got busy=%b v=%b need 0 0", busy, rk_valid);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_start(2'b00, K128);
        repeat (19) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_pre: got %b need 1", busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_data !== '0 || rk_round !== 4'd0 || rk_last !== 1'b0) begin
            n_err++; $display("FAIL rmid_outputs: got busy=%b v=%b d=%h r=%0d l=%b need all 0",
                              busy, rk_valid, rk_data, rk_round, rk_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(2'b00, K128);
        wait_first_valid(cyc);
        n_cmp++; if (cyc != 41) begin n_err++; $display("FAIL rmid_latency: got cycle %0d need 41", cyc); end
        n_cmp++;
        if (rk_round !== 4'd10 || rk_data !== rk128[10]) begin
            n_err++; $display("FAIL rmid_first: got r=%0d d=%h need r=10 d=%h", rk_round, rk_data, rk128[10]);
        end
        collect_keys(1'b0, 64);
        check_aes128_stream("rmid");
    endtask

    initial begin
        rk128[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk128[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk128[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk128[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk128[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk128[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk128[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk128[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk128[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk128[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk128[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        rst_n    = 1'b0;
        mode     = 2'b00;
        key_in   = '0;
        start    = 1'b0;
        rk_ready = 1'b0;

        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_backpressure();
        test_mode_rsvd();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
